// File: rtl/mem_pkg.sv
// Shared encodings for the MEM-stage data-memory access path.
package mem_pkg;

   typedef enum logic [1:0] {
      MEM_BYTE = 2'b00,
      MEM_HALF = 2'b01,
      MEM_WORD = 2'b10
   } mem_size_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_BUSY = 2'b01,
      ST_DONE = 2'b10
   } mem_state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian byte-lane logic: byte enables, store-data replication and
// load shift/extend. Size 2'b11 behaves as a word.
module mem_lane_align (
   input  logic [1:0]  addr_lo_i,
   input  logic [1:0]  size_i,
   input  logic        signed_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rdata_i,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o,
   output logic [31:0] rdata_o
);
   import mem_pkg::*;

   logic [1:0]  off;
   logic [31:0] shifted;

   always_comb begin
      off     = 2'b00;
      be_o    = 4'b1111;
      wdata_o = wdata_i;
      case (size_i)
         MEM_BYTE: begin
            off     = addr_lo_i;
            be_o    = 4'b0001 << addr_lo_i;
            wdata_o = {4{wdata_i[7:0]}};
         end
         MEM_HALF: begin
            // addr[0] is ignored: halves are aligned down to their lane pair
            off     = {addr_lo_i[1], 1'b0};
            be_o    = 4'b0011 << off;
            wdata_o = {2{wdata_i[15:0]}};
         end
         default: ;
      endcase

      shifted = rdata_i >> {off, 3'b000};
      case (size_i)
         MEM_BYTE: rdata_o = {{24{signed_i & shifted[7]}}, shifted[7:0]};
         MEM_HALF: rdata_o = {{16{signed_i & shifted[15]}}, shifted[15:0]};
         default:  rdata_o = shifted;
      endcase
   end

endmodule

// File: rtl/mem_access_stage.sv
// MEM-stage data-memory access controller: req/ack bus FSM with stall and
// registered load result. Define MEM_ALIGN_CHECK_EN to trap misaligned accesses.
module mem_access_stage #(
   parameter int unsigned TIMEOUT_CYCLES = 16,
   parameter logic [31:0] ERR_RDATA      = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        pc_rst,
   input  logic [31:0] m_aluResult,
   input  logic [31:0] m_writeData,
   input  logic        m_memRead,
   input  logic        m_memWrite,
   input  logic [1:0]  m_size,
   input  logic        m_signed,
   output logic [31:0] dmem_readData,
   output logic        mem_stall,
   output logic        mem_err,
   output logic        mem_misaligned,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata
);
   import mem_pkg::*;

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

   mem_state_e  state_q;
   logic [7:0]  cnt_q;
   logic [1:0]  off_q, size_q;
   logic        sgn_q;
   logic        req_q, we_q, err_q;
   logic [31:0] addr_q, wdata_q, rd_q;
   logic [3:0]  be_q;

   logic        acc, is_store;
   logic [1:0]  la_addr, la_size;
   logic        la_sgn;
   logic [3:0]  la_be;
   logic [31:0] la_wdata, la_rdata;

   assign acc      = m_memRead | m_memWrite;
   assign is_store = m_memWrite & ~m_memRead;

   // Lane logic sees live EX/MEM fields in IDLE and the latched ones afterwards
   always_comb begin
      la_addr = off_q;
      la_size = size_q;
      la_sgn  = sgn_q;
      if (state_q == ST_IDLE) begin
         la_addr = m_aluResult[1:0];
         la_size = m_size;
         la_sgn  = m_signed;
      end
   end

   mem_lane_align u_lane (
      .addr_lo_i (la_addr),
      .size_i    (la_size),
      .signed_i  (la_sgn),
      .wdata_i   (m_writeData),
      .rdata_i   (bus_rdata),
      .be_o      (la_be),
      .wdata_o   (la_wdata),
      .rdata_o   (la_rdata)
   );

`ifdef MEM_ALIGN_CHECK_EN
   logic misaligned, mis_q;
   always_comb begin
      case (m_size)
         MEM_BYTE: misaligned = 1'b0;
         MEM_HALF: misaligned = m_aluResult[0];
         default:  misaligned = |m_aluResult[1:0];
      endcase
   end
   assign mem_misaligned = mis_q;
`else
   assign mem_misaligned = 1'b0;
`endif

   always_comb begin
      case (state_q)
         ST_IDLE: mem_stall = acc;
         ST_BUSY: mem_stall = 1'b1;
         default: mem_stall = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (pc_rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         off_q   <= '0;
         size_q  <= '0;
         sgn_q   <= 1'b0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         rd_q    <= '0;
`ifdef MEM_ALIGN_CHECK_EN
         mis_q   <= 1'b0;
`endif
      end else begin
         err_q <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
         mis_q <= 1'b0;
`endif
         case (state_q)
            ST_IDLE: begin
               if (acc) begin
                  off_q  <= m_aluResult[1:0];
                  size_q <= m_size;
                  sgn_q  <= m_signed;
`ifdef MEM_ALIGN_CHECK_EN
                  if (misaligned) begin
                     state_q <= ST_DONE;
                     mis_q   <= 1'b1;
                     if (!is_store) rd_q <= ERR_RDATA;
                  end else
`endif
                  begin
                     req_q   <= 1'b1;
                     we_q    <= is_store;
                     addr_q  <= {m_aluResult[31:2], 2'b00};
                     be_q    <= la_be;
                     wdata_q <= la_wdata;
                     cnt_q   <= '0;
                     state_q <= ST_BUSY;
                  end
               end
            end
            ST_BUSY: begin
               cnt_q <= cnt_q + 8'd1;
               // ack takes priority over a timeout in the same cycle
               if (bus_ack) begin
                  req_q   <= 1'b0;
                  if (!we_q) rd_q <= la_rdata;
                  state_q <= ST_DONE;
               end else if (cnt_q == CNT_LAST) begin
                  req_q   <= 1'b0;
                  err_q   <= 1'b1;
                  if (!we_q) rd_q <= ERR_RDATA;
                  state_q <= ST_DONE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign dmem_readData = rd_q;
   assign mem_err       = err_q;
   assign bus_req       = req_q;
   assign bus_we        = we_q;
   assign bus_addr      = addr_q;
   assign bus_be        = be_q;
   assign bus_wdata     = wdata_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed vector table, reset-mid-access sequence
// and randomized accesses checked against a byte-level reference model.
module tb_mem_access_stage;

   localparam int          TO  = 16;
   localparam logic [31:0] ERR = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        pc_rst;
   logic [31:0] m_aluResult, m_writeData;
   logic        m_memRead, m_memWrite;
   logic [1:0]  m_size;
   logic        m_signed;
   logic [31:0] dmem_readData;
   logic        mem_stall, mem_err, mem_misaligned;
   logic        bus_req, bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        bus_ack;
   logic [31:0] bus_rdata;

   int vectors = 0;
   int miscompares = 0;
   logic [31:0] model_rd;

   always #5 clk = ~clk;

   mem_access_stage #(.TIMEOUT_CYCLES(TO), .ERR_RDATA(ERR)) dut (
      .clk(clk), .pc_rst(pc_rst),
      .m_aluResult(m_aluResult), .m_writeData(m_writeData),
      .m_memRead(m_memRead), .m_memWrite(m_memWrite),
      .m_size(m_size), .m_signed(m_signed),
      .dmem_readData(dmem_readData), .mem_stall(mem_stall),
      .mem_err(mem_err), .mem_misaligned(mem_misaligned),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
      .bus_be(bus_be), .bus_wdata(bus_wdata),
      .bus_ack(bus_ack), .bus_rdata(bus_rdata)
   );

   typedef struct {
      logic        re, we;
      logic [1:0]  size;
      logic        sgn;
      logic [31:0] addr, wd, rdata;
      int          ack_after;   // BUSY cycles before ack; >= TO means never
      logic [3:0]  be;
      logic [31:0] wdata, rd;
      int          stall;
      logic        err, mis;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: compute lanes from byte count and offset with plain arithmetic
   function automatic vec_t model(input vec_t v, input logic [31:0] cur_rd);
      vec_t   r = v;
      int     n, off, base;
      longint val;
      bit     mis, timed_out;
      off  = int'(v.addr[1:0]);
      n    = (v.size == 2'd0) ? 1 : (v.size == 2'd1) ? 2 : 4;
      base = (off / n) * n;
`ifdef MEM_ALIGN_CHECK_EN
      mis = (off % n) != 0;
`else
      mis = 1'b0;
`endif
      r.be = '0;
      for (int lane = 0; lane < 4; lane++) begin
         if (lane >= base && lane < base + n) r.be[lane] = 1'b1;
         r.wdata[lane*8 +: 8] = v.wd[(lane % n)*8 +: 8];
      end
      val = 0;
      for (int i = 0; i < n; i++)
         val = val + (longint'(v.rdata[(base+i)*8 +: 8]) << (8*i));
      if (v.sgn && n < 4 && val >= (longint'(1) << (8*n-1)))
         val = val - (longint'(1) << (8*n));
      timed_out = v.ack_after >= TO;
      r.mis   = mis;
      r.err   = !mis && timed_out;
      r.stall = mis ? 1 : (timed_out ? TO + 1 : v.ack_after + 2);
      if (v.re) r.rd = (mis || timed_out) ? ERR : val[31:0];
      else      r.rd = cur_rd;
      return r;
   endfunction

   task automatic run_txn(input vec_t v, input string tag);
      int stall_cnt, busy;
      @(negedge clk);
      m_memRead = v.re; m_memWrite = v.we; m_aluResult = v.addr;
      m_writeData = v.wd; m_size = v.size; m_signed = v.sgn; bus_ack = 1'b0;
      stall_cnt = 0; busy = 0;
      #1;
      while (mem_stall === 1'b1 && stall_cnt < 400) begin
         stall_cnt++;
         if (bus_req === 1'b1) begin
            if (busy == 0) begin
               chk({tag, " bus_be"}, {28'd0, bus_be}, {28'd0, v.be});
               chk({tag, " bus_wdata"}, bus_wdata, v.wdata);
               chk({tag, " bus_addr"}, bus_addr, v.addr & ~32'd3);
               chk({tag, " bus_we"}, {31'd0, bus_we}, {31'd0, v.we & ~v.re});
            end
            bus_ack   = (busy == v.ack_after);
            bus_rdata = bus_ack ? v.rdata : $urandom;
            busy++;
         end
         @(negedge clk);
         bus_ack = 1'b0;
         #1;
      end
      chk({tag, " stall_cycles"}, stall_cnt, v.stall);
      chk({tag, " mem_err"}, {31'd0, mem_err}, {31'd0, v.err});
      chk({tag, " mem_misaligned"}, {31'd0, mem_misaligned}, {31'd0, v.mis});
      chk({tag, " dmem_readData"}, dmem_readData, v.rd);
      chk({tag, " bus_req_done"}, {31'd0, bus_req}, 32'd0);
      m_memRead = 1'b0; m_memWrite = 1'b0;
      @(negedge clk);
      chk({tag, " err_pulse_end"}, {31'd0, mem_err | mem_misaligned}, 32'd0);
      chk({tag, " rd_hold"}, dmem_readData, v.rd);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, " bus_req"}, {31'd0, bus_req}, 32'd0);
      chk({tag, " bus_we"}, {31'd0, bus_we}, 32'd0);
      chk({tag, " mem_stall"}, {31'd0, mem_stall}, 32'd0);
      chk({tag, " mem_err"}, {31'd0, mem_err}, 32'd0);
      chk({tag, " mem_misaligned"}, {31'd0, mem_misaligned}, 32'd0);
      chk({tag, " bus_addr"}, bus_addr, 32'd0);
      chk({tag, " bus_be"}, {28'd0, bus_be}, 32'd0);
      chk({tag, " bus_wdata"}, bus_wdata, 32'd0);
      chk({tag, " dmem_readData"}, dmem_readData, 32'd0);
   endtask

   vec_t tbl[12];
   vec_t rv, ev;

   initial begin
      //         re    we    size   sgn   addr          wd            rdata         ack  be       wdata         rd            stl err   mis
      tbl[0]  = '{1'b0, 1'b1, 2'd2, 1'b0, 32'h0000_0010, 32'h1234_5678, 32'h0,        0,  4'b1111, 32'h1234_5678, 32'h0,        2,  1'b0, 1'b0};
      tbl[1]  = '{1'b1, 1'b0, 2'd0, 1'b1, 32'h0000_0003, 32'h0,        32'h80FF_0000, 0,  4'b1000, 32'h0,        32'hFFFF_FF80, 2,  1'b0, 1'b0};
      tbl[2]  = '{1'b1, 1'b0, 2'd0, 1'b0, 32'h0000_0003, 32'h0,        32'h80FF_0000, 2,  4'b1000, 32'h0,        32'h0000_0080, 4,  1'b0, 1'b0};
      tbl[3]  = '{1'b0, 1'b1, 2'd1, 1'b0, 32'h0000_0006, 32'hAAAA_BEEF, 32'h0,        1,  4'b1100, 32'hBEEF_BEEF, 32'h0000_0080, 3,  1'b0, 1'b0};
      tbl[4]  = '{1'b1, 1'b0, 2'd1, 1'b1, 32'h0000_0006, 32'h0,        32'hBEEF_1234, 0,  4'b1100, 32'h0,        32'hFFFF_BEEF, 2,  1'b0, 1'b0};
      tbl[5]  = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0008, 32'h0,        32'h5555_5555, 255, 4'b1111, 32'h0,       ERR,           17, 1'b1, 1'b0};
      tbl[6]  = '{1'b0, 1'b1, 2'd2, 1'b0, 32'h0000_0020, 32'hDEAD_BEEF, 32'h0,        15, 4'b1111, 32'hDEAD_BEEF, ERR,          17, 1'b0, 1'b0};
`ifdef MEM_ALIGN_CHECK_EN
      tbl[7]  = '{1'b1, 1'b0, 2'd1, 1'b0, 32'h0000_0005, 32'h0,        32'h1234_8001, 0,  4'b0011, 32'h0,        ERR,           1,  1'b0, 1'b1};
      tbl[8]  = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0002, 32'h0,        32'hCAFE_F00D, 1,  4'b1111, 32'h0,        ERR,           1,  1'b0, 1'b1};
`else
      tbl[7]  = '{1'b1, 1'b0, 2'd1, 1'b0, 32'h0000_0005, 32'h0,        32'h1234_8001, 0,  4'b0011, 32'h0,        32'h0000_8001, 2,  1'b0, 1'b0};
      tbl[8]  = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0002, 32'h0,        32'hCAFE_F00D, 1,  4'b1111, 32'h0,        32'hCAFE_F00D, 3,  1'b0, 1'b0};
`endif
      tbl[9]  = '{1'b1, 1'b1, 2'd0, 1'b0, 32'h0000_0001, 32'h1122_3344, 32'h0000_7F00, 0,  4'b0010, 32'h4444_4444, 32'h0000_007F, 2,  1'b0, 1'b0};
      tbl[10] = '{1'b0, 1'b1, 2'd0, 1'b0, 32'h0000_0002, 32'h0000_00A5, 32'h0,        4,  4'b0100, 32'hA5A5_A5A5, 32'h0000_007F, 6,  1'b0, 1'b0};
      tbl[11] = '{1'b1, 1'b0, 2'd3, 1'b1, 32'h0000_000C, 32'h0,        32'h89AB_CDEF, 0,  4'b1111, 32'h0,        32'h89AB_CDEF, 2,  1'b0, 1'b0};

      pc_rst = 1'b1; m_aluResult = '0; m_writeData = '0; m_memRead = 1'b0;
      m_memWrite = 1'b0; m_size = '0; m_signed = 1'b0; bus_ack = 1'b0; bus_rdata = '0;
      repeat (2) @(negedge clk);
      check_all_zero("reset");
      pc_rst = 1'b0;

      for (int i = 0; i < 12; i++) run_txn(tbl[i], $sformatf("tbl%0d", i));
      model_rd = tbl[11].rd;

      // Reset in the third BUSY cycle of a load, then a stray ack
      @(negedge clk);
      m_memRead = 1'b1; m_aluResult = 32'h0000_0040; m_size = 2'd2; m_signed = 1'b0;
      repeat (3) @(negedge clk);
      chk("rstmid busy_req", {31'd0, bus_req}, 32'd1);
      pc_rst = 1'b1; m_memRead = 1'b0;
      @(negedge clk);
      pc_rst = 1'b0;
      check_all_zero("rstmid");
      bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      bus_ack = 1'b0;
      chk("rstmid late_ack rd", dmem_readData, 32'd0);
      chk("rstmid late_ack req", {31'd0, bus_req | mem_stall}, 32'd0);
      model_rd = '0;

      for (int i = 0; i < 40; i++) begin
         int k, a;
         k = $urandom_range(0, 3);
         rv.re    = (k < 2);
         rv.we    = (k < 2) ? 1'($urandom_range(0, 1)) : 1'b1;
         rv.size  = 2'($urandom_range(0, 3));
         rv.sgn   = 1'($urandom_range(0, 1));
         rv.addr  = $urandom;
         rv.wd    = $urandom;
         rv.rdata = $urandom;
         a = $urandom_range(0, 9);
         rv.ack_after = (a == 9) ? 255 : (a >= 7) ? $urandom_range(0, TO - 1) : $urandom_range(0, 2);
         ev = model(rv, model_rd);
         run_txn(ev, $sformatf("rnd%0d", i));
         model_rd = ev.rd;
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
